pipelined_ripple_adder: RTL and testbench

//   Parametrised successor to the 4-bit combinational ripple adder.
//   - Adds or subtracts two WIDTH-bit operands.
//   - The carry chain is cut into STAGES equal chunks with a register between chunks.
//   - Valid/ready handshake on both sides; full stall on backpressure.
//   - Sits between operand producers and result consumers in the datapath.

---
 rtl/pipelined_ripple_adder_if.sv | 27 ++
 rtl/pipelined_ripple_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for pipelined_ripple_adder.
// The producer/consumer side uses master, the adder uses slave.
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, cin, sub, in_valid, out_ready,
        input  in_ready, sum, cout, ovf, out_valid
    );

    modport slave (
        input  a, b, cin, sub, in_valid, out_ready,
        output in_ready, sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract whose ripple carry chain is split into STAGES registered chunks,
// with valid/ready on both sides and a whole-pipeline stall under backpressure.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic                    CLK,
    input logic                    RST_N,
    pipelined_ripple_adder_if.slave io
);
    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_ripple_adder: WIDTH must be >= 1 and divisible by STAGES");
        end
    endgenerate

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0]            ovf_q, ovf_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] bx_q, bx_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;

    // Entry k of these is what stage k consumes: entry 0 is the input port, entry k+1 is register k.
    logic [STAGES:0]              pv_s, pc_s;
    logic [STAGES:0][WIDTH-1:0]   pa_s, pbx_s, psum_s;
    logic                         adv_s;

    // Ripples only the bits of chunk k; returns {ovf, carry out, partial sum}.
    function automatic logic [WIDTH+1:0] chunk_add(
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] bx_v,
        input logic [WIDTH-1:0] sum_v,
        input logic             c_in,
        input int               k
    );
        logic             c;
        logic             c_msb;
        logic [WIDTH-1:0] s;
        c     = c_in;
        c_msb = 1'b0;
        s     = sum_v;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i / CHUNK) == k) begin
                if (i == WIDTH - 1) begin
                    c_msb = c;
                end else begin
                    c_msb = c_msb;
                end
                s[i] = a_v[i] ^ bx_v[i] ^ c;
                c    = (a_v[i] & bx_v[i]) | (c & (a_v[i] ^ bx_v[i]));
            end else begin
                s[i] = s[i];
            end
        end
        return {c_msb ^ c, c, s};
    endfunction

    // Next-state for every stage: hold on stall, else shift, loading zeros for bubbles.
    always_comb begin
        logic [WIDTH+1:0] res;
        res    = '0;
        adv_s  = !valid_q[STAGES-1] || io.out_ready;
        pv_s   = {valid_q, io.in_valid};
        pa_s   = {a_q, io.a};
        pbx_s  = {bx_q, (io.sub ? ~io.b : io.b)};
        psum_s = {sum_q, {WIDTH{1'b0}}};
        pc_s   = {carry_q, (io.sub ? 1'b1 : io.cin)};
        valid_d = valid_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        bx_d    = bx_q;
        sum_d   = sum_q;
        for (int k = 0; k < STAGES; k++) begin
            res = chunk_add(pa_s[k], pbx_s[k], psum_s[k], pc_s[k], k);
            if (!adv_s) begin
                valid_d[k] = valid_q[k];
            end else if (pv_s[k]) begin
                valid_d[k] = 1'b1;
                a_d[k]     = pa_s[k];
                bx_d[k]    = pbx_s[k];
                sum_d[k]   = res[WIDTH-1:0];
                carry_d[k] = res[WIDTH];
                ovf_d[k]   = res[WIDTH+1];
            end else begin
                valid_d[k] = 1'b0;
                a_d[k]     = {WIDTH{1'b0}};
                bx_d[k]    = {WIDTH{1'b0}};
                sum_d[k]   = {WIDTH{1'b0}};
                carry_d[k] = 1'b0;
                ovf_d[k]   = 1'b0;
            end
        end
    end

    // Pipeline registers; reset flushes every in-flight transaction.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            a_q     <= '0;
            bx_q    <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            sum_q   <= sum_d;
        end
    end

    assign io.in_ready  = adv_s;
    assign io.out_valid = valid_q[STAGES-1];
    assign io.sum       = sum_q[STAGES-1];
    assign io.cout      = carry_q[STAGES-1];
    assign io.ovf       = ovf_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and streamed checks of pipelined_ripple_adder in three configurations:
// 8/2 (main), 4/1 and 8/8.
module tb_pipelined_ripple_adder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pipelined_ripple_adder_if #(.WIDTH(8)) m_if ();
    pipelined_ripple_adder_if #(.WIDTH(4)) w4_if ();
    pipelined_ripple_adder_if #(.WIDTH(8)) s8_if ();

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) u_dut (.CLK(clk), .RST_N(rst_n), .io(m_if.slave));
    pipelined_ripple_adder #(.WIDTH(4), .STAGES(1)) u_w4  (.CLK(clk), .RST_N(rst_n), .io(w4_if.slave));
    pipelined_ripple_adder #(.WIDTH(8), .STAGES(8)) u_s8  (.CLK(clk), .RST_N(rst_n), .io(s8_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [8:0] res;
        int         cyc;
    } exp_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction through the 8/2 instance with OUT_READY held high.
    task automatic run_one(input vec_t v, input int idx);
        int lat;
        bit got;
        @(negedge clk);
        m_if.a = v.a; m_if.b = v.b; m_if.cin = v.cin; m_if.sub = v.sub; m_if.in_valid = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), {31'd0, m_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        m_if.in_valid = 1'b0;
        got = 1'b0;
        lat = 1;
        for (int n = 0; n < 10 && !got; n++) begin
            if (m_if.out_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check($sformatf("vec%0d_got_result", idx), {31'd0, got}, 32'd1);
        check($sformatf("vec%0d_latency", idx), lat, 32'd2);
        check($sformatf("vec%0d_sum", idx), {24'd0, m_if.sum}, {24'd0, v.sum});
        check($sformatf("vec%0d_cout", idx), {31'd0, m_if.cout}, {31'd0, v.cout});
        check($sformatf("vec%0d_ovf", idx), {31'd0, m_if.ovf}, {31'd0, v.ovf});
    endtask

    initial begin
        exp_t        q[$];
        exp_t        e;
        int          sent;
        int          recvd;
        int          stale;
        int          sa, sb, sr;
        logic [7:0]  ra, rb;
        logic        rc, rs;
        logic [8:0]  full;
        logic [7:0]  bp_sum[4];
        logic [3:0]  w4_a[4];
        logic [3:0]  w4_b[4];
        logic [3:0]  w4_s[4];

        tests = 0;
        fails = 0;
        //          a      b      cin   sub   sum    cout  ovf
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[7] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[9] = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};

        m_if.a = 8'h00; m_if.b = 8'h00; m_if.cin = 1'b0; m_if.sub = 1'b0;
        m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
        w4_if.a = 4'h0; w4_if.b = 4'h0; w4_if.cin = 1'b0; w4_if.sub = 1'b0;
        w4_if.in_valid = 1'b0; w4_if.out_ready = 1'b1;
        s8_if.a = 8'h00; s8_if.b = 8'h00; s8_if.cin = 1'b0; s8_if.sub = 1'b0;
        s8_if.in_valid = 1'b0; s8_if.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, m_if.out_valid}, 32'd0);
        check("rst_sum", {24'd0, m_if.sum}, 32'd0);
        check("rst_cout_ovf", {30'd0, m_if.cout, m_if.ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_after", {31'd0, m_if.in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i], i);
        end

        // Backpressure: four ops, stall once the first result is presented.
        bp_sum = '{8'h02, 8'h04, 8'h06, 8'h08};
        @(negedge clk);
        m_if.sub = 1'b0; m_if.cin = 1'b0;
        m_if.a = 8'h01; m_if.b = 8'h01; m_if.in_valid = 1'b1;
        @(negedge clk);
        m_if.a = 8'h02; m_if.b = 8'h02;
        @(negedge clk);
        check("bp_first_valid", {31'd0, m_if.out_valid}, 32'd1);
        check("bp_first_sum", {24'd0, m_if.sum}, {24'd0, bp_sum[0]});
        m_if.out_ready = 1'b0;
        m_if.a = 8'h03; m_if.b = 8'h03;
        #1;
        check("bp_in_ready_low", {31'd0, m_if.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_in_ready", {31'd0, m_if.in_ready}, 32'd0);
            check("bp_stall_hold", {23'd0, m_if.out_valid, m_if.sum}, {23'd0, 1'b1, bp_sum[0]});
        end
        m_if.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_result%0d", i + 1), {23'd0, m_if.out_valid, m_if.sum},
                  {23'd0, 1'b1, bp_sum[i]});
            if (i == 1) begin
                m_if.a = 8'h04; m_if.b = 8'h04;
            end else begin
                m_if.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_no_duplicate", {31'd0, m_if.out_valid}, 32'd0);

        // Reset one cycle after accepting 0x12+0x34.
        @(negedge clk);
        m_if.a = 8'h12; m_if.b = 8'h34; m_if.in_valid = 1'b1;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, m_if.out_valid}, 32'd0);
        check("mid_rst_sum", {24'd0, m_if.sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", {31'd0, m_if.in_ready}, 32'd1);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_if.out_valid || m_if.sum == 8'h46) stale++;
            @(negedge clk);
        end
        check("mid_rst_no_stale", stale, 32'd0);

        // WIDTH=4, STAGES=1 streamed back to back, latency 1.
        w4_a = '{4'd0, 4'd0, 4'd1, 4'd1};
        w4_b = '{4'd0, 4'd1, 4'd0, 4'd1};
        w4_s = '{4'd0, 4'd1, 4'd1, 4'd2};
        q.delete();
        sent = 0;
        recvd = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (w4_if.out_valid) begin
                if (q.size() == 0) begin
                    check("w4_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("w4_result", {27'd0, w4_if.cout, w4_if.sum}, {27'd0, e.res[4:0]});
                    check("w4_latency", cyc - e.cyc, 32'd1);
                    recvd++;
                end
            end
            if (sent < 4) begin
                w4_if.a = w4_a[sent]; w4_if.b = w4_b[sent]; w4_if.in_valid = 1'b1;
                e.res = {4'd0, 1'b0, w4_s[sent]};
                e.cyc = cyc;
                q.push_back(e);
                sent++;
            end else begin
                w4_if.in_valid = 1'b0;
            end
        end
        check("w4_count", recvd, 32'd4);

        // WIDTH=8, STAGES=8: 1000 random vectors at full throughput.
        q.delete();
        sent = 0;
        recvd = 0;
        for (int cyc = 0; cyc < 1100 && (sent < 1000 || q.size() != 0); cyc++) begin
            @(negedge clk);
            if (s8_if.out_valid) begin
                if (q.size() == 0) begin
                    check("s8_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("s8_result", {22'd0, s8_if.ovf, s8_if.cout, s8_if.sum}, {22'd0, e.res, 1'b0} >> 1 | {22'd0, e.cyc[0], 9'd0});
                    if (recvd == 0) check("s8_latency", cyc - e.cyc[31:1], 32'd8);
                    recvd++;
                end
            end
            if (sent < 1000) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                sa = int'($signed(ra));
                sb = int'($signed(rb));
                if (rs) begin
                    full = {1'b0, ra} - {1'b0, rb};
                    full[8] = (ra >= rb);
                    sr = sa - sb;
                end else begin
                    full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
                    sr = sa + sb + int'(rc);
                end
                s8_if.a = ra; s8_if.b = rb; s8_if.cin = rc; s8_if.sub = rs; s8_if.in_valid = 1'b1;
                e.res = full;
                e.cyc = (cyc << 1) | ((sr > 127 || sr < -128) ? 1 : 0);
                q.push_back(e);
                sent++;
            end else begin
                s8_if.in_valid = 1'b0;
            end
        end
        check("s8_count", recvd, 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
